// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'h1;
      2'b01:   return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
    return ({1'b0, off} + size_bytes(sz)) > 3'd4;
  endfunction

  // Stores have no unsigned variants, so funct3[2] is only legal on loads.
  function automatic logic legal_op(input logic we, input logic [2:0] f3);
    logic known;
    known = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (f3 == F3_BU) || (f3 == F3_HU);
    return known && !(we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store mask/data positioning and load
// shift plus sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        upper_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_lo_i,
  input  logic [31:0] rd_hi_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wd_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  m8;
  logic [63:0] d64;
  logic [31:0] v;

  assign m8      = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
  assign d64     = {32'b0, wdata_i} << {off_i, 3'b000};
  assign wmask_o = upper_i ? m8[7:4] : m8[3:0];
  assign wd_o    = upper_i ? d64[63:32] : d64[31:0];
  assign v       = 32'({rd_hi_i, rd_lo_i} >> {off_i, 3'b000});

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{v[7]}}, v[7:0]};
      F3_H:    rdata_o = {{16{v[15]}}, v[15:0]};
      F3_W:    rdata_o = v;
      F3_BU:   rdata_o = {24'b0, v[7:0]};
      F3_HU:   rdata_o = {16'b0, v[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit: splits requests into word-aligned memory cycles.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses in two.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int AW   = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [AW-1:0]   mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic [3:0]      mem_wmask,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

  logic            accept, illegal_in, upper, split_now;
  logic [AW-1:0]   base;
  logic [XLEN-1:0] rd_lo, rd_hi, ld_data, lane_wd;
  logic [3:0]      lane_mask;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid & req_ready;
  assign base       = {addr_q[AW-1:2], 2'b00};
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] w0_q;

  assign illegal_in = !legal_op(req_we, req_funct3);
  assign split_now  = crosses(f3_q[1:0], addr_q[1:0]);
  assign upper      = (state_q == ACC1);
  // The high word is taken live from mem_rd in ACC1; only the low word needs holding.
  assign rd_lo      = upper ? w0_q : mem_rd;
  assign rd_hi      = upper ? mem_rd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q <= '0;
    end else if (state_q == ACC0) begin
      w0_q <= mem_rd;
    end
  end
`else
  assign illegal_in = !legal_op(req_we, req_funct3) | crosses(req_funct3[1:0], req_addr[1:0]);
  assign split_now  = 1'b0;
  assign upper      = 1'b0;
  assign rd_lo      = mem_rd;
  assign rd_hi      = '0;
`endif

  lsu_lane_align u_lane (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .upper_i  (upper),
    .wdata_i  (wdata_q),
    .rd_lo_i  (rd_lo),
    .rd_hi_i  (rd_hi),
    .wmask_o  (lane_mask),
    .wd_o     (lane_wd),
    .rdata_o  (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_a        = '0;
    mem_wd       = '0;
    mem_wmask    = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal_in) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        mem_a     = base;
        mem_wd    = lane_wd;
        mem_wmask = we_q ? lane_mask : 4'h0;
        if (split_now) begin
          state_d = ACC1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : ld_data;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        mem_a        = base + AW'(4);
        mem_wd       = lane_wd;
        mem_wmask    = we_q ? lane_mask : 4'h0;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? '0 : ld_data;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-level reference memory model.
module tb_lsu_align;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rd;

  lsu_align #(.AW(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_wmask(mem_wmask), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Bench memory: 64 words indexed by address bits [7:2].
  logic [31:0] mem [64];
  logic        clr = 1'b0, pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          cyc = 0;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  // Reference model state
  logic [7:0]  rmem [logic [31:0]];
  int          n_cmp = 0, n_bad = 0;
  int          exp_due = -1, acc_cyc = 0, last_cyc = -100;
  logic [31:0] exp_rdata = '0, last_rdata = '0;
  logic        exp_err = 1'b0, last_err = 1'b0, exp_nowrite = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_cross(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) + nbytes(f3)) > 4;
  endfunction

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit illegal;
    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (we && f3[2]);
    return illegal || (!SPLIT && model_cross(f3, a));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nbytes(f3); i++) v = v | (32'(rb(a + 32'(i))) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic check_word(input string name, input logic [31:0] a);
    chk(name, mem[a[7:2]], {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)});
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = a[7:2]; pre_val = val;
    for (int i = 0; i < 4; i++) rmem[a + 32'(i)] = val[8*i +: 8];
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Drive one request; returns just after the accept edge with expectations set.
  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bit err;
    int lat;
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b1; req_funct3 = 3'($urandom());
    req_addr = $urandom(); req_wdata = $urandom();
    err = model_err(we, f3, a);
    lat = err ? 1 : (model_cross(f3, a) ? 3 : 2);
    acc_cyc = cyc;
    exp_due = cyc + lat - 1;
    exp_err = err;
    exp_rdata = (we || err) ? 32'h0 : model_load(f3, a);
    exp_nowrite = !we || err;
    last_rdata = 32'h5A5A_5A5A; last_err = 1'bx; last_cyc = -100;
    if (we && !err)
      for (int i = 0; i < nbytes(f3); i++) rmem[a + 32'(i)] = wd[8*i +: 8];
  endtask

  task automatic wait_done();
    while (cyc <= exp_due) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_resp(input string name, input logic [31:0] data, input logic err,
                          input int lat);
    chk({name, "_rdata"}, last_rdata, data);
    chk({name, "_err"}, 32'(last_err), 32'(err));
    chk({name, "_latency"}, 32'(last_cyc - acc_cyc + 1), 32'(lat));
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    chk("resp_valid_timing", 32'(resp_valid), 32'(cyc == exp_due));
    if (resp_valid) begin
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      last_rdata = resp_rdata; last_err = resp_err; last_cyc = cyc;
    end else begin
      chk("resp_rdata_idle", resp_rdata, 32'h0);
      chk("resp_err_idle", 32'(resp_err), 32'h0);
    end
    chk("mem_a_aligned", 32'(mem_a[1:0]), 32'h0);
    if (exp_nowrite || !rst_n) chk("wmask_quiet", 32'(mem_wmask), 32'h0);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    preload(32'h0000_0080, 32'h8899_AABB);
    preload(32'hFFFF_FFFC, 32'hCAFE_F00D);
    preload(32'h0000_0000, 32'h1122_3344);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store then load
    start(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    chk("sw10_mask", 32'(mem_wmask), 32'hF);
    chk("sw10_addr", mem_a, 32'h10);
    chk("sw10_wd", mem_wd, 32'hDEAD_BEEF);
    wait_done();
    chk_resp("sw10", 32'h0, 1'b0, 2);
    check_word("sw10_mem", 32'h10);
    start(1'b0, 3'b010, 32'h10, 32'h0);
    wait_done();
    chk_resp("lw10", 32'hDEAD_BEEF, 1'b0, 2);

    // Byte/half extension from preloaded word 0x80
    start(1'b0, 3'b000, 32'h81, 32'h0); wait_done(); chk_resp("lb81", 32'hFFFF_FFAA, 1'b0, 2);
    start(1'b0, 3'b100, 32'h81, 32'h0); wait_done(); chk_resp("lbu81", 32'h0000_00AA, 1'b0, 2);
    start(1'b0, 3'b001, 32'h82, 32'h0); wait_done(); chk_resp("lh82", 32'hFFFF_8899, 1'b0, 2);
    start(1'b0, 3'b101, 32'h82, 32'h0); wait_done(); chk_resp("lhu82", 32'h0000_8899, 1'b0, 2);
    start(1'b0, 3'b001, 32'h81, 32'h0); wait_done(); chk_resp("lh81", 32'hFFFF_99AA, 1'b0, 2);

    // Crossing half store/load at offset 3
    start(1'b1, 3'b001, 32'h43, 32'h0000_1234);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("sh43_acc0_mask", 32'(mem_wmask), 32'h8);
    chk("sh43_acc0_addr", mem_a, 32'h40);
    chk("sh43_acc0_byte", 32'(mem_wd[31:24]), 32'h34);
    @(posedge clk); #1;
    chk("sh43_acc1_mask", 32'(mem_wmask), 32'h1);
    chk("sh43_acc1_addr", mem_a, 32'h44);
    chk("sh43_acc1_byte", 32'(mem_wd[7:0]), 32'h12);
`endif
    wait_done();
    check_word("sh43_mem40", 32'h40);
    check_word("sh43_mem44", 32'h44);
    start(1'b0, 3'b001, 32'h43, 32'h0);
    wait_done();
`ifdef LSU_MISALIGN_SPLIT_EN
    chk_resp("lh43", 32'h0000_1234, 1'b0, 3);
`else
    chk_resp("lh43", 32'h0, 1'b1, 1);
`endif

    // Crossing word load, illegal store, illegal funct3
    start(1'b0, 3'b010, 32'h21, 32'h0);
    wait_done();
`ifndef LSU_MISALIGN_SPLIT_EN
    chk_resp("lw21", 32'h0, 1'b1, 1);
`endif
    start(1'b1, 3'b100, 32'h30, 32'hFFFF_FFFF);
    wait_done();
    chk_resp("sw_f3_100", 32'h0, 1'b1, 1);
    check_word("sw_f3_100_mem", 32'h30);
    start(1'b0, 3'b011, 32'h80, 32'h0);
    wait_done();
    chk_resp("ld_f3_011", 32'h0, 1'b1, 1);

    // Address wrap on the second half
    start(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lwfe_acc0_addr", mem_a, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("lwfe_acc1_addr", mem_a, 32'h0);
    wait_done();
    chk_resp("lwfe", 32'h3344_CAFE, 1'b0, 3);
`else
    wait_done();
    chk_resp("lwfe", 32'h0, 1'b1, 1);
`endif

    // Reset mid-operation: first half stays written, no response
`ifdef LSU_MISALIGN_SPLIT_EN
    start(1'b1, 3'b010, 32'h62, 32'hA1B2_C3D4);
    @(posedge clk); #1;
    chk("rstmid_in_acc1_mask", 32'(mem_wmask), 32'h3);
    rmem.delete(32'h64); rmem.delete(32'h65);
`else
    start(1'b1, 3'b010, 32'h60, 32'hA1B2_C3D4);
    chk("rstmid_in_acc0_mask", 32'(mem_wmask), 32'hF);
    for (int i = 0; i < 4; i++) rmem.delete(32'h60 + 32'(i));
`endif
    exp_due = -1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wmask", 32'(mem_wmask), 32'h0);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'h0);
    chk("rstmid_req_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_ready_after", 32'(req_ready), 32'h1);
    check_word("rstmid_mem60", 32'h60);
    check_word("rstmid_mem64", 32'h64);
    start(1'b0, 3'b010, 32'h60, 32'h0);
    wait_done();
`ifdef LSU_MISALIGN_SPLIT_EN
    chk_resp("lw60_after_rst", 32'hC3D4_0000, 1'b0, 2);
`else
    chk_resp("lw60_after_rst", 32'h0, 1'b0, 2);
`endif
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit between the core datapath and the byte-masked data memory.
- Accepts one load or store request per handshake, converts it into word-aligned memory cycles, and drives the memory word address, write data and 4-bit byte write mask.
- Extracts and sign/zero-extends load data from the combinational memory read port.
- Misaligned accesses that cross a word boundary are split into two word accesses by a small FSM.

Parameters:
- AW, 32, request/memory address width.
- XLEN, 32, data width; only 32 supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- req_addr  in  AW  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or (without split) misaligned access
- mem_a  out  AW  byte address to memory, always word aligned (bits[1:0]=0)
- mem_wd  out  XLEN  lane-positioned write data
- mem_wmask  out  4  byte write enables; written on the clk edge ending the cycle
- mem_rd  in  XLEN  combinational read data for mem_a

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_a=0; mem_wd=0; mem_wmask=0.
- States: IDLE, ACC0, ACC1, RESP.
- Request capture:
  - req_ready=1 only in IDLE; handshake = req_valid & req_ready.
  - On handshake, register we/funct3/addr/wdata.
- Decode at accept:
  - off = addr[1:0]; size = 1/2/4 bytes.
  - cross = (size + off) > 4.
  - illegal = funct3 not in {000, 001, 010, 100, 101}, or (we & funct3[2]).
- Transitions:
  - IDLE -> RESP if illegal.
  - IDLE -> ACC0 otherwise.
  - ACC0 -> ACC1 if cross, else RESP.
  - ACC1 -> RESP.
  - RESP -> IDLE.
- Per-state outputs:
  - ACC0: mem_a = {addr[AW-1:2], 2'b00}.
  - ACC1: mem_a = ACC0 address + 4, wrapping 0xFFFFFFFC -> 0x00000000.
  - mem_wmask nonzero only in ACC0/ACC1 with we=1; 0 in IDLE/RESP and for loads.
- Store lanes:
  - 8-bit mask m8 = (size==1 ? 0x01 : size==2 ? 0x03 : 0x0F) << off.
  - 64-bit data d64 = wdata << (8*off).
  - ACC0 drives m8[3:0] and d64[31:0]; ACC1 drives m8[7:4] and d64[63:32].
- Load:
  - ACC0 samples mem_rd into w0; ACC1 samples into w1 (w1=0 when not crossing).
  - v = {w1, w0} >> (8*off).
  - Extend: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes v[31:0].
- Response:
  - resp_valid=1 for exactly the RESP cycle, with resp_rdata/resp_err held valid.
  - Both are registered and cleared to 0 on the next cycle.
- Latency (accept edge to resp_valid): aligned/non-crossing = 2 cycles; crossing = 3; illegal = 1.
- Throughput: next request accepted in the cycle after RESP.
- Inputs outside the handshake are ignored; request fields are not required stable after accept.
- Reset mid-operation:
  - Immediate return to IDLE; mem_wmask drops to 0 asynchronously; no response is produced.
  - A first-half store already written in ACC0 is not rolled back.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses split into ACC0+ACC1 as above.
- Undefined:
  - Any access with cross=1 is treated as illegal: IDLE -> RESP, resp_err=1, no memory write.
  - The ACC1 state and the w1 register are not synthesized.
  - Non-crossing misaligned accesses (e.g. LH at off=1) still succeed.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, ACC0, ACC1, RESP}.
  - size-to-mask function.
- Sub-module lsu_lane_align (combinational):
  - store path: m8/d64 generation.
  - load path: 64-bit shift + sign/zero extension.
  - Top keeps the FSM and registers.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one cycle with mem_wmask=0xF at mem_a=0x10; load resp_rdata=0xDEADBEEF, resp_err=0; resp_valid 2 cycles after accept.
- Word 0x80 holds 0x8899AABB (preloaded): LB 0x81 -> 0xFFFFFFAA; LBU 0x81 -> 0x000000AA; LH 0x82 -> 0xFFFF8899; LHU 0x82 -> 0x00008899.
- SH 0x43 data 0x1234 (split enabled) -> ACC0 mask 0x8 at 0x40 with byte 0x34; ACC1 mask 0x1 at 0x44 with byte 0x12; LH 0x43 returns 0x00001234 with 3-cycle latency.
- Split disabled: LW 0x21 -> resp_err=1 one cycle after accept, mem_wmask stays 0, resp_rdata=0; illegal SW with funct3=100 gives the same response.
- LW 0xFFFFFFFE, split enabled -> second access at mem_a=0x00000000; data = {word0[15:0], wordFFFFFFFC[31:16]}.
- Assert rst_n low during ACC1 of a crossing SW -> mem_wmask=0 immediately; no resp_valid; req_ready=1 after release; a subsequent LW completes normally.
